// File: rtl/ro_burst_scheduler.sv
// ro_burst_scheduler: register-programmed ring-oscillator burst sequencer (ramp, hold, off, repeat).
// Define RO_ACTIVITY_CNT_EN to add the 48-bit bank-cycle activity counter at 0x618/0x61C.
module ro_burst_scheduler #(
   parameter int          NUM_RO     = 8,
   parameter logic [31:0] CTRL_ADDR  = 32'h0000_0600,
   parameter logic [31:0] ON_ADDR    = 32'h0000_0604,
   parameter logic [31:0] OFF_ADDR   = 32'h0000_0608,
   parameter logic [31:0] BURST_ADDR = 32'h0000_060C,
   parameter logic [31:0] MASK_ADDR  = 32'h0000_0610,
   parameter logic [31:0] STAT_ADDR  = 32'h0000_0614,
   parameter int          RAMP_STEP  = 16
) (
   input  logic              clk_main_a0,
   input  logic              rst_main,
   input  logic              wready,
   input  logic [31:0]       wr_addr,
   input  logic [31:0]       wdata,
   input  logic              arvalid_q,
   input  logic [31:0]       araddr_q,
   input  logic              rready,
   output logic              rvalid,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic [NUM_RO-1:0] ro_en,
   output logic              busy,
   output logic              burst_done
);
   typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, ON = 2'd2, OFF = 2'd3} state_t;
   state_t state, state_n;
   logic [31:0] on_cycles, off_cycles, on_l, on_l_n, off_l, off_l_n, cnt, cnt_n, on_m1, off_m1, rd_mux;
   logic [15:0] burst_count, bursts_done, bursts_done_n;
   logic [NUM_RO-1:0] bank_mask, mask_l, mask_l_n, ro_en_n, pend, next_bit, ramp_en;
   logic cont, err_start, err_start_n, burst_done_n, wr_ctrl, start, stop, start_ok, accept, enter;

`ifdef RO_ACTIVITY_CNT_EN
   localparam int PW = $clog2(NUM_RO + 1);
   localparam logic [31:0] ACT_LO_ADDR = 32'h0000_0618;
   localparam logic [31:0] ACT_HI_ADDR = 32'h0000_061C;
   logic [47:0] act;
   logic [48:0] act_sum;
   logic [PW-1:0] pop;
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_RO; i++) pop = pop + PW'(ro_en[i]);
   end
   assign act_sum = {1'b0, act} + 49'(pop);
   always_ff @(posedge clk_main_a0 or posedge rst_main)
      if (rst_main) act <= '0;
      else act <= accept ? '0 : act_sum[48] ? '1 : act_sum[47:0];
`endif

   // Stop outranks start when both bits arrive in one write.
   assign wr_ctrl  = wready && wr_addr == CTRL_ADDR;
   assign stop     = wr_ctrl && wdata[1];
   assign start    = wr_ctrl && wdata[0] && !wdata[1];
   assign start_ok = on_cycles != '0 && bank_mask != '0 && (burst_count != '0 || wdata[2]);
   assign accept   = start && start_ok && state == IDLE;
   assign on_m1    = on_l == '0 ? '0 : on_l - 32'd1;
   assign off_m1   = off_l == '0 ? '0 : off_l - 32'd1;
   assign pend     = mask_l & ~ro_en;
   assign next_bit = pend & -pend;
   assign ramp_en  = ro_en | next_bit;
   assign busy     = state != IDLE;
   assign rresp    = 2'b00;

   always_ff @(posedge clk_main_a0 or posedge rst_main)
      if (rst_main) begin
         cont        <= 1'b0;
         on_cycles   <= '0;
         off_cycles  <= '0;
         burst_count <= '0;
         bank_mask   <= '0;
      end else if (wready) begin
         if (wr_addr == CTRL_ADDR)  cont        <= wdata[2];
         if (wr_addr == ON_ADDR)    on_cycles   <= wdata;
         if (wr_addr == OFF_ADDR)   off_cycles  <= wdata;
         if (wr_addr == BURST_ADDR) burst_count <= wdata[15:0];
         if (wr_addr == MASK_ADDR)  bank_mask   <= wdata[NUM_RO-1:0];
      end

   // The edge that enables the last masked bank also enters ON.
   always_comb begin
      state_n       = state;
      ro_en_n       = ro_en;
      cnt_n         = cnt;
      mask_l_n      = mask_l;
      on_l_n        = on_l;
      off_l_n       = off_l;
      bursts_done_n = bursts_done;
      burst_done_n  = 1'b0;
      err_start_n   = err_start;
      enter         = 1'b0;
      case (state)
         IDLE: if (start) begin
            err_start_n = !start_ok;
            enter       = accept;
            if (accept) bursts_done_n = '0;
         end
         RAMP: if (pend == '0 || (cnt == '0 && ramp_en == mask_l)) begin
            state_n = ON;
            ro_en_n = mask_l;
            cnt_n   = on_m1;
         end else if (cnt == '0) begin
            ro_en_n = ramp_en;
            cnt_n   = 32'(RAMP_STEP - 1);
         end else cnt_n = cnt - 32'd1;
         ON: if (cnt == '0) begin
            state_n       = OFF;
            ro_en_n       = '0;
            burst_done_n  = 1'b1;
            cnt_n         = off_m1;
            bursts_done_n = bursts_done == 16'hFFFF ? bursts_done : bursts_done + 16'd1;
         end else cnt_n = cnt - 32'd1;
         OFF: if (cnt != '0) cnt_n = cnt - 32'd1;
            else if (cont || bursts_done < burst_count) enter = 1'b1;
            else state_n = IDLE;
      endcase
      if (enter) begin
         state_n  = RAMP;
         mask_l_n = bank_mask;
         on_l_n   = on_cycles;
         off_l_n  = off_cycles;
         ro_en_n  = bank_mask & -bank_mask;
         cnt_n    = 32'(RAMP_STEP - 1);
      end
      if (stop) begin
         state_n = IDLE;
         ro_en_n = '0;
      end
   end

   always_ff @(posedge clk_main_a0 or posedge rst_main)
      if (rst_main) begin
         state       <= IDLE;
         ro_en       <= '0;
         cnt         <= '0;
         mask_l      <= '0;
         on_l        <= '0;
         off_l       <= '0;
         bursts_done <= '0;
         burst_done  <= 1'b0;
         err_start   <= 1'b0;
      end else begin
         state       <= state_n;
         ro_en       <= ro_en_n;
         cnt         <= cnt_n;
         mask_l      <= mask_l_n;
         on_l        <= on_l_n;
         off_l       <= off_l_n;
         bursts_done <= bursts_done_n;
         burst_done  <= burst_done_n;
         err_start   <= err_start_n;
      end

   always_comb begin
      rd_mux = 32'hDEAD_BEEF;
      case (araddr_q)
         CTRL_ADDR:   rd_mux = {29'b0, cont, 2'b00};
         ON_ADDR:     rd_mux = on_cycles;
         OFF_ADDR:    rd_mux = off_cycles;
         BURST_ADDR:  rd_mux = {16'b0, burst_count};
         MASK_ADDR:   rd_mux = 32'(bank_mask);
         STAT_ADDR:   rd_mux = {state, err_start, 13'b0, bursts_done};
`ifdef RO_ACTIVITY_CNT_EN
         ACT_LO_ADDR: rd_mux = act[31:0];
         ACT_HI_ADDR: rd_mux = {16'b0, act[47:32]};
`endif
         default:     rd_mux = 32'hDEAD_BEEF;
      endcase
   end

   // A request arriving while a response is pending is dropped.
   always_ff @(posedge clk_main_a0 or posedge rst_main)
      if (rst_main) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else if (rvalid) begin
         if (rready) begin
            rvalid <= 1'b0;
            rdata  <= '0;
         end
      end else if (arvalid_q) begin
         rvalid <= 1'b1;
         rdata  <= rd_mux;
      end
endmodule

// File: tb/tb_ro_burst_scheduler.sv
// tb_ro_burst_scheduler: directed and randomized burst runs checked against a timeline model
// derived from the ramp/on/off durations.
module tb_ro_burst_scheduler;
   localparam logic [31:0] CTRL = 32'h600, ONA = 32'h604, OFFA = 32'h608;
   localparam logic [31:0] BURST = 32'h60C, MASK = 32'h610, STAT = 32'h614;
   localparam int RS = 16;

   logic clk = 1'b0, rst_main = 1'b1, wready = 1'b0, arvalid_q = 1'b0, rready = 1'b0;
   logic [31:0] wr_addr = '0, wdata = '0, araddr_q = '0;
   logic rvalid, busy, burst_done;
   logic [31:0] rdata, d, held;
   logic [1:0] rresp;
   logic [7:0] ro_en;
   int checks = 0, errors = 0;
   logic [7:0] m_mask;
   int m_on, m_off, m_nb, last_nb, stop_t;
   bit m_cont;
   logic [31:0] regs [6] = '{CTRL, ONA, OFFA, BURST, MASK, STAT};

   ro_burst_scheduler dut (
      .clk_main_a0(clk), .rst_main(rst_main), .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
      .arvalid_q(arvalid_q), .araddr_q(araddr_q), .rready(rready), .rvalid(rvalid), .rdata(rdata),
      .rresp(rresp), .ro_en(ro_en), .busy(busy), .burst_done(burst_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] v);
      wready = 1'b1; wr_addr = a; wdata = v;
      @(negedge clk);
      wready = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      arvalid_q = 1'b1; araddr_q = a;
      @(negedge clk);
      arvalid_q = 1'b0;
      chk("rvalid_set", 32'(rvalid), 32'd1);
      v = rdata; rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      chk("rvalid_clr", 32'(rvalid), 32'd0);
   endtask

   function automatic int ramp_len();
      int n = $countones(m_mask);
      return n > 1 ? (n - 1) * RS : 1;
   endfunction

   function automatic int period();
      return ramp_len() + m_on + (m_off == 0 ? 1 : m_off);
   endfunction

   // Expected outputs t cycles after the first RAMP cycle of a run.
   task automatic model(input int t, output logic [7:0] en, output logic bsy, output logic bd);
      int per = period();
      int rl = ramp_len();
      int tb = t % per;
      int k = 0;
      en = '0;
      bsy = m_cont || (t / per < m_nb);
      bd = 1'b0;
      if (bsy) begin
         bd = (tb == rl + m_on);
         if (tb < rl) begin
            for (int i = 0; i < 8; i++) if (m_mask[i]) begin
               if (k * RS <= tb) en[i] = 1'b1;
               k++;
            end
         end else if (tb < rl + m_on) en = m_mask;
      end
   endtask

   task automatic step_check(input int t);
      logic [7:0] en;
      logic bsy, bd;
      model(t, en, bsy, bd);
      chk($sformatf("ro_en@%0d", t), 32'(ro_en), 32'(en));
      chk($sformatf("busy@%0d", t), 32'(busy), 32'(bsy));
      chk($sformatf("burst_done@%0d", t), 32'(burst_done), 32'(bd));
   endtask

   task automatic setup(input logic [7:0] mk, input int on, input int off, input int nb, input bit cont);
      m_mask = mk; m_on = on; m_off = off; m_nb = nb; m_cont = cont;
      wr(MASK, 32'(mk)); wr(ONA, 32'(on)); wr(OFFA, 32'(off)); wr(BURST, 32'(nb));
      wr(CTRL, cont ? 32'h5 : 32'h1);
   endtask

   task automatic run_to_idle();
      int len = m_nb * period() + 2;
      for (int t = 0; t < len; t++) begin
         step_check(t);
         @(negedge clk);
      end
      last_nb = m_nb;
   endtask

   initial begin
      #3;
      chk("rst_ro_en", 32'(ro_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_burst_done", 32'(burst_done), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_rresp", 32'(rresp), 32'd0);
      @(negedge clk);
      rst_main = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rd(regs[i], d);
         chk($sformatf("rst_reg_%h", regs[i]), d, 32'd0);
      end
      // Directed two-burst run with a sparse mask.
      setup(8'h05, 10, 4, 2, 1'b0);
      run_to_idle();
      rd(STAT, d); chk("stat_directed", d, 32'd2);
      rd(ONA, d); chk("rd_on", d, 32'd10);
      rd(OFFA, d); chk("rd_off", d, 32'd4);
      rd(BURST, d); chk("rd_burst", d, 32'd2);
      rd(MASK, d); chk("rd_mask", d, 32'h05);
      rd(CTRL, d); chk("rd_ctrl", d, 32'd0);
      for (int r = 0; r < 5; r++) begin
         setup(8'($urandom_range(1, 255)), $urandom_range(1, 12), $urandom_range(0, 5),
               $urandom_range(1, 3), 1'b0);
         run_to_idle();
         rd(STAT, d); chk($sformatf("stat_rand%0d", r), d, 32'(m_nb));
      end
      // Start with an empty mask is refused.
      wr(MASK, 32'd0); wr(ONA, 32'd5); wr(BURST, 32'd1); wr(CTRL, 32'h5);
      for (int t = 0; t < 20; t++) begin
         chk("badstart_ro_en", 32'(ro_en), 32'd0);
         chk("badstart_busy", 32'(busy), 32'd0);
         @(negedge clk);
      end
      rd(STAT, d); chk("stat_err", d, 32'h2000_0000 | 32'(last_nb));
      rd(CTRL, d); chk("rd_ctrl_cont", d, 32'h4);
      // Continuous run, redundant start while busy, stop mid-ON of the fourth burst.
      setup(8'($urandom_range(1, 255)), 5, 0, 0, 1'b1);
      stop_t = 3 * period() + ramp_len() + 2;
      for (int t = 0; t <= stop_t; t++) begin
         step_check(t);
         wready = (t == 3 || t == stop_t);
         wr_addr = CTRL;
         wdata = (t == stop_t) ? 32'h2 : 32'h5;
         @(negedge clk);
      end
      wready = 1'b0;
      chk("stop_ro_en", 32'(ro_en), 32'd0);
      chk("stop_busy", 32'(busy), 32'd0);
      // Read held with rready low; a second request meanwhile is ignored.
      arvalid_q = 1'b1; araddr_q = STAT;
      @(negedge clk);
      araddr_q = 32'h700;
      held = rdata;
      chk("hold_stat", held, 32'd3);
      for (int i = 0; i < 5; i++) begin
         chk("hold_rvalid", 32'(rvalid), 32'd1);
         chk("hold_rdata", rdata, held);
         chk("hold_rresp", 32'(rresp), 32'd0);
         @(negedge clk);
      end
      arvalid_q = 1'b0; rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      chk("hold_release", 32'(rvalid), 32'd0);
      rd(32'h700, d); chk("unmapped", d, 32'hDEAD_BEEF);
`ifdef RO_ACTIVITY_CNT_EN
      setup(8'h03, 100, 0, 1, 1'b0);
      run_to_idle();
      rd(32'h618, d); chk("act_lo", d, 32'd216);
      rd(32'h61C, d); chk("act_hi", d, 32'd0);
`else
      rd(32'h618, d); chk("act_lo_absent", d, 32'hDEAD_BEEF);
      rd(32'h61C, d); chk("act_hi_absent", d, 32'hDEAD_BEEF);
`endif
      // Asynchronous reset in the middle of a ramp.
      setup(8'hFF, 10, 2, 1, 1'b0);
      for (int t = 0; t < 20; t++) begin
         step_check(t);
         @(negedge clk);
      end
      #2 rst_main = 1'b1;
      #1;
      chk("async_ro_en", 32'(ro_en), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_main = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rd(regs[i], d);
         chk($sformatf("post_rst_%h", regs[i]), d, 32'd0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ro_burst_scheduler.md
Name: ro_burst_scheduler

Overview:
Register-programmed controller that sequences an array of ring-oscillator (power-waster) enables for on-chip power/thermal stress experiments. Enables are ramped in bank-by-bank to limit di/dt, held for a programmed on-time, then dropped for an off-time, repeated for N bursts or continuously. Sits between the CL register write/read path (same wready/wr_addr/wdata and arvalid_q/araddr_q/rvalid/rready handshake as the existing CL registers) and the RO instances' enable inputs.

Parameters:
NUM_RO, 8, number of RO banks; one enable bit each (1..32)
CTRL_ADDR, 32'h0000_0600, control register: bit0 start (self-clearing), bit1 stop (self-clearing), bit2 continuous
ON_ADDR, 32'h0000_0604, ON_CYCLES, 32-bit hold time with all masked banks enabled
OFF_ADDR, 32'h0000_0608, OFF_CYCLES, 32-bit off time
BURST_ADDR, 32'h0000_060C, BURST_COUNT, 16-bit number of bursts in [15:0]
MASK_ADDR, 32'h0000_0610, BANK_MASK in [NUM_RO-1:0]
STAT_ADDR, 32'h0000_0614, read-only status
RAMP_STEP, 16, cycles between successive bank enables during ramp

Ports:
clk_main_a0  in  1  main clock
rst_main  in  1  asynchronous reset, active high
wready  in  1  write strobe, qualifies wr_addr/wdata
wr_addr  in  32  write address
wdata  in  32  write data
arvalid_q  in  1  read request
araddr_q  in  32  read address
rready  in  1  read data accepted
rvalid  out  1  read data valid
rdata  out  32  read data
rresp  out  2  read response, always 2'b00
ro_en  out  NUM_RO  per-bank RO enable
busy  out  1  high in any state but IDLE
burst_done  out  1  one-cycle pulse at end of each burst's ON phase

Behaviour:
- Reset (async assert, sync-released use): all config registers 0, state IDLE, ro_en=0, busy=0, burst_done=0, rvalid=0, rdata=0, rresp=0.
- Config writes accepted any cycle; changes to ON/OFF/MASK mid-run take effect at next phase entry (latched on RAMP entry).
- States: IDLE, RAMP, ON, OFF.
- IDLE: start write with ON_CYCLES!=0, BANK_MASK!=0 and (BURST_COUNT!=0 or continuous) -> RAMP next cycle; otherwise start ignored, STATUS.err_start set (cleared by next valid start).
- RAMP: lowest unset masked bank enabled on entry cycle, next masked bank every RAMP_STEP cycles; unmasked banks never enabled. Cycle after last masked bank enabled -> ON.
- ON: counter loads ON_CYCLES; after exactly ON_CYCLES cycles in ON, all ro_en drop in the same cycle, burst_done pulses, bursts_done++ (16-bit saturating) -> OFF.
- OFF: after OFF_CYCLES cycles (0 treated as 1) -> RAMP if continuous or bursts_done<BURST_COUNT, else IDLE.
- Stop write: from any state, ro_en=0 next cycle, -> IDLE, bursts_done retained. Stop and start in same write: stop wins.
- Start while busy: ignored.
- Read path: arvalid_q -> rvalid=1 next cycle with rdata; hold rdata/rvalid until rvalid&rready, then clear next cycle; arvalid_q during pending rvalid ignored. Config regs read back as written (CTRL reads {29'b0,continuous,2'b00}). STAT = {state[1:0] at [31:30], err_start at [29], 13'b0, bursts_done[15:0]}. Unmapped address returns 32'hDEAD_BEEF.
- bursts_done cleared on each accepted start.

Optional Feature:
RO_ACTIVITY_CNT_EN: when defined, adds a 48-bit counter incrementing by popcount(ro_en) each cycle (bank-cycles of activity); low 32 bits read at 32'h0000_0618, high 16 bits at 32'h0000_061C ([15:0]); counter cleared on reset and accepted start, saturates at all-ones. When undefined, no counter; both addresses return 32'hDEAD_BEEF.

Test Plan:
- Reset mid-RAMP (rst_main asserted asynchronously) -> ro_en=0 same cycle without clock edge; all reads return 0 afterwards.
- MASK=8'h05, ON=10, OFF=4, BURST=2, RAMP_STEP=16, start -> bit0 up, bit2 up 16 cycles later, ON 10 cycles, all drop, 4 off, repeat; 2 burst_done pulses, STAT[15:0]=2, busy low, state IDLE.
- Start with MASK=0 -> busy stays 0, STAT[29]=1, ro_en never asserted.
- Continuous, ON=5, OFF=0 -> OFF lasts 1 cycle, runs indefinitely; stop write during ON -> ro_en=0 next cycle, IDLE, bursts_done held.
- Read STAT with rready held low 5 cycles -> rvalid and rdata stable 5 cycles; read to 32'h700 -> 32'hDEAD_BEEF, rresp=0.
- With RO_ACTIVITY_CNT_EN, MASK=8'h03, ON=100, BURST=1 -> counter = 1*RAMP_STEP + 2*100 = 216 read at 32'h618.
